// File: rtl/counter_bcd_mux.sv
// Multi-digit BCD up/down counter with prescaled step, parallel load, wrap pulse,
// and a registered multiplexed seven-segment scan driver.

module counter_bcd_mux_digit (
  input  logic       up_i,
  input  logic       cin_i,
  input  logic [3:0] d_i,
  input  logic [3:0] lv_i,
  output logic [3:0] nxt_o,
  output logic       cout_o,
  output logic [3:0] sat_o
);
  always_comb begin
    nxt_o  = d_i;
    cout_o = 1'b0;
    if (cin_i) begin
      if (up_i) begin
        if (d_i >= 4'd9) begin
          nxt_o  = 4'd0;
          cout_o = 1'b1;
        end else begin
          nxt_o = d_i + 4'd1;
        end
      end else begin
        if (d_i == 4'd0) begin
          nxt_o  = 4'd9;
          cout_o = 1'b1;
        end else begin
          nxt_o = d_i - 4'd1;
        end
      end
    end
    sat_o = (lv_i > 4'd9) ? 4'd9 : lv_i;
  end
endmodule

module counter_bcd_mux #(
  parameter int DIGITS   = 2,
  parameter int TICK_DIV = 1000,
  parameter int SCAN_DIV = 1
) (
  input  logic                  clk1k,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  carry,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     dig
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [6:0] GLYPH0 = 7'b0111111;

  logic [DIGITS-1:0][3:0] bcd_q, bcd_d, nxt, sat;
  logic [DIGITS:0]        cy;
  logic [PW-1:0]          p_q, p_d;
  logic [SW-1:0]          sc_q, sc_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic                   carry_q, carry_d;
  logic [6:0]             seg_q, seg_d;
  logic [DIGITS-1:0]      dig_q, dig_d;
  logic                   step;

  // Ripple chain: digit 0 always sees a carry-in; the chain only commits on a step.
  assign cy[0] = 1'b1;
  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    counter_bcd_mux_digit u_dig (
      .up_i   (up),
      .cin_i  (cy[i]),
      .d_i    (bcd_q[i]),
      .lv_i   (load_val[4*i +: 4]),
      .nxt_o  (nxt[i]),
      .cout_o (cy[i+1]),
      .sat_o  (sat[i])
    );
  end

  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'd0:    glyph = 7'b0111111;
      4'd1:    glyph = 7'b0000110;
      4'd2:    glyph = 7'b1011011;
      4'd3:    glyph = 7'b1001111;
      4'd4:    glyph = 7'b1100110;
      4'd5:    glyph = 7'b1101101;
      4'd6:    glyph = 7'b1111101;
      4'd7:    glyph = 7'b0000111;
      4'd8:    glyph = 7'b1111111;
      default: glyph = 7'b1101111;
    endcase
  endfunction

  always_comb begin
    p_d     = p_q;
    bcd_d   = bcd_q;
    carry_d = 1'b0;
    step    = en && (p_q == PW'(TICK_DIV - 1));
    if (load) begin
      bcd_d = sat;
      p_d   = '0;
    end else if (en) begin
      if (step) begin
        p_d     = '0;
        bcd_d   = nxt;
        carry_d = cy[DIGITS];
      end else begin
        p_d = p_q + PW'(1);
      end
    end
  end

  // Scan runs regardless of en/load; glyph is taken from the pre-update count.
  always_comb begin
    sc_d  = sc_q + SW'(1);
    idx_d = idx_q;
    if (sc_q == SW'(SCAN_DIV - 1)) begin
      sc_d  = '0;
      idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
    end
    seg_d = glyph(bcd_q[idx_d]);
    dig_d = DIGITS'(1) << idx_d;
  end

  always_ff @(posedge clk1k) begin
    if (rst) begin
      bcd_q   <= '0;
      p_q     <= '0;
      carry_q <= 1'b0;
      sc_q    <= '0;
      idx_q   <= '0;
      seg_q   <= GLYPH0;
      dig_q   <= DIGITS'(1);
    end else begin
      bcd_q   <= bcd_d;
      p_q     <= p_d;
      carry_q <= carry_d;
      sc_q    <= sc_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      dig_q   <= dig_d;
    end
  end

  assign bcd   = bcd_q;
  assign carry = carry_q;
  assign seg   = seg_q;
  assign dig   = dig_q;
endmodule

// File: tb/tb_counter_bcd_mux.sv
// Four differently parameterised counters share one stimulus stream and are checked
// against a decimal-integer reference model each clock.

module tb_counter_bcd_mux;
  logic        clk1k = 1'b0;
  logic        rst = 1'b1, en = 1'b0, up = 1'b1, load = 1'b0;
  logic [31:0] lv = '0;

  logic [7:0]  bcd0, bcd1;
  logic [11:0] bcd2;
  logic [3:0]  bcd3;
  logic        car0, car1, car2, car3;
  logic [6:0]  seg0, seg1, seg2, seg3;
  logic [1:0]  dig0, dig1;
  logic [2:0]  dig2;
  logic [0:0]  dig3;

  counter_bcd_mux #(.DIGITS(2), .TICK_DIV(4), .SCAN_DIV(1)) u0 (
    .clk1k(clk1k), .rst(rst), .en(en), .up(up), .load(load), .load_val(lv[7:0]),
    .bcd(bcd0), .carry(car0), .seg(seg0), .dig(dig0));
  counter_bcd_mux #(.DIGITS(2), .TICK_DIV(1), .SCAN_DIV(1)) u1 (
    .clk1k(clk1k), .rst(rst), .en(en), .up(up), .load(load), .load_val(lv[7:0]),
    .bcd(bcd1), .carry(car1), .seg(seg1), .dig(dig1));
  counter_bcd_mux #(.DIGITS(3), .TICK_DIV(1), .SCAN_DIV(3)) u2 (
    .clk1k(clk1k), .rst(rst), .en(en), .up(up), .load(load), .load_val(lv[11:0]),
    .bcd(bcd2), .carry(car2), .seg(seg2), .dig(dig2));
  counter_bcd_mux #(.DIGITS(1), .TICK_DIV(3), .SCAN_DIV(2)) u3 (
    .clk1k(clk1k), .rst(rst), .en(en), .up(up), .load(load), .load_val(lv[3:0]),
    .bcd(bcd3), .carry(car3), .seg(seg3), .dig(dig3));

  always #5 clk1k = ~clk1k;

  int total = 0, bad = 0;
  int ND[4] = '{2, 2, 3, 1};
  int TD[4] = '{4, 1, 1, 3};
  int SD[4] = '{1, 1, 3, 2};
  int val[4], p[4], sc[4], idx[4], ecar[4], eseg[4], edig[4];
  logic [6:0] GLY[10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                          7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};

  function automatic int pw10(input int n);
    int r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic int digit_of(input int v, input int i);
    return (v / pw10(i)) % 10;
  endfunction

  function automatic logic [31:0] to_bcd(input int v, input int nd);
    logic [31:0] r = '0;
    for (int i = 0; i < nd; i++) r = r | (32'(digit_of(v, i)) << (4 * i));
    return r;
  endfunction

  task automatic model_edge();
    for (int k = 0; k < 4; k++) begin
      int m = pw10(ND[k]);
      if (rst) begin
        val[k] = 0; p[k] = 0; sc[k] = 0; idx[k] = 0; ecar[k] = 0;
        eseg[k] = GLY[0]; edig[k] = 1;
      end else begin
        if (sc[k] == SD[k] - 1) begin
          sc[k] = 0;
          idx[k] = (idx[k] + 1) % ND[k];
        end else sc[k]++;
        eseg[k] = GLY[digit_of(val[k], idx[k])];
        edig[k] = 1 << idx[k];
        ecar[k] = 0;
        if (load) begin
          int nv = 0;
          for (int i = 0; i < ND[k]; i++) begin
            int d = int'(lv[4*i +: 4]);
            nv += ((d > 9) ? 9 : d) * pw10(i);
          end
          val[k] = nv; p[k] = 0;
        end else if (en) begin
          if (p[k] == TD[k] - 1) begin
            p[k] = 0;
            if (up) begin
              if (val[k] == m - 1) begin val[k] = 0; ecar[k] = 1; end
              else val[k]++;
            end else begin
              if (val[k] == 0) begin val[k] = m - 1; ecar[k] = 1; end
              else val[k]--;
            end
          end else p[k]++;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_inst(input int k, input logic [31:0] b, input logic [31:0] c,
                          input logic [31:0] s, input logic [31:0] d);
    chk($sformatf("u%0d.bcd", k), b, to_bcd(val[k], ND[k]));
    chk($sformatf("u%0d.carry", k), c, 32'(ecar[k]));
    chk($sformatf("u%0d.seg", k), s, 32'(eseg[k]));
    chk($sformatf("u%0d.dig", k), d, 32'(edig[k]));
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk1k);
    #1;
    chk_inst(0, 32'(bcd0), 32'(car0), 32'(seg0), 32'(dig0));
    chk_inst(1, 32'(bcd1), 32'(car1), 32'(seg1), 32'(dig1));
    chk_inst(2, 32'(bcd2), 32'(car2), 32'(seg2), 32'(dig2));
    chk_inst(3, 32'(bcd3), 32'(car3), 32'(seg3), 32'(dig3));
  endtask

  initial begin
    // reset and first steps
    rst = 1'b1;
    repeat (3) tick();
    chk("rst.bcd", 32'(bcd0), 32'h00);
    chk("rst.dig", 32'(dig0), 32'b01);
    chk("rst.seg", 32'(seg0), 32'b0111111);
    rst = 1'b0; en = 1'b1; up = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (n == 3) chk("pre_first_step", 32'(bcd0), 32'h00);
      if (n == 4) chk("step4", 32'(bcd0), 32'h01);
      if (n == 8) chk("step8", 32'(bcd0), 32'h02);
    end
    chk("step40", 32'(bcd0), 32'h10);

    // load near top and wrap up
    load = 1'b1; lv = 32'h98; tick();
    chk("load98", 32'(bcd1), 32'h98);
    load = 1'b0;
    tick(); chk("up99", 32'(bcd1), 32'h99); chk("up99.carry", 32'(car1), 0);
    tick(); chk("wrap00", 32'(bcd1), 32'h00); chk("wrap00.carry", 32'(car1), 1);
    tick(); chk("after_wrap.carry", 32'(car1), 0);

    // wrap down and load saturation
    load = 1'b1; lv = 32'h00; up = 1'b0; tick();
    load = 1'b0;
    tick(); chk("dn99", 32'(bcd1), 32'h99); chk("dn99.carry", 32'(car1), 1);
    tick(); chk("dn98", 32'(bcd1), 32'h98); chk("dn98.carry", 32'(car1), 0);
    load = 1'b1; lv = 32'hAF; tick();
    chk("loadAF", 32'(bcd1), 32'h99);

    // freeze with p=2 on the divide-by-4 counter
    lv = 32'h37; up = 1'b1; tick();
    load = 1'b0; repeat (2) tick();
    en = 1'b0; repeat (10) tick();
    chk("frozen", 32'(bcd0), 32'h37);
    en = 1'b1; tick();
    chk("resume1", 32'(bcd0), 32'h37);
    tick();
    chk("resume2", 32'(bcd0), 32'h38);

    // scan of a fixed value
    load = 1'b1; lv = 32'h137; tick();
    load = 1'b0; en = 1'b0;
    repeat (8) tick();

    // reset beats load and a pending step; load beats step
    en = 1'b1; load = 1'b1; lv = 32'h55; rst = 1'b1; tick();
    chk("rstwin.bcd", 32'(bcd1), 32'h00);
    chk("rstwin.seg", 32'(seg1), 32'b0111111);
    rst = 1'b0; lv = 32'h42; tick();
    chk("loadwin", 32'(bcd1), 32'h42);
    load = 1'b0;

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      rst  = ($urandom_range(63) == 0);
      load = ($urandom_range(15) == 0);
      en   = ($urandom_range(3) != 0);
      up   = $urandom_range(1);
      lv   = $urandom;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
